// File: rtl/adpll_pkg.sv
// Shared ADPLL types and constants: phase-detector FSM states, saturation limit, default error width.
package adpll_pkg;

    localparam int unsigned ADPLL_ERROR_WIDTH = 6;

    typedef enum logic [1:0] {
        PDET_IDLE,
        PDET_REF_LEAD,
        PDET_FB_LEAD,
        PDET_DRAIN
    } pdet_state_t;

    // Largest symmetric magnitude of a signed word: 2^(width-1)-1.
    function automatic int unsigned pdet_sat_limit(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/phase_detector_counter_edge_sync.sv
// edge_sync: 2-flop synchronizer plus registered rising-edge pulse for an asynchronous input.
module edge_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic edge_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       dly_q;
    logic       edge_q;
    logic [1:0] fill_q;

    // dly_q holds high until the sync chain carries real samples, so a level
    // already high at reset release must first go low before it counts as an edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b1;
            fill_q  <= 2'b00;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            dly_q   <= fill_q[1] ? sync2_q : 1'b1;
            edge_q  <= fill_q[1] & sync2_q & ~dly_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/phase_detector_counter.sv
// Counter-based bang-magnitude phase detector; optional lock detector under ADPLL_LOCK_DETECT_EN.
module phase_detector_counter
    import adpll_pkg::*;
#(
    parameter int unsigned ERROR_WIDTH = ADPLL_ERROR_WIDTH
`ifdef ADPLL_LOCK_DETECT_EN
    ,
    parameter int unsigned LOCK_TOL    = 2,
    parameter int unsigned LOCK_COUNT  = 16
`endif
) (
    input  logic                          gen_clk_i,
    input  logic                          reset_i,
    input  logic                          ref_i,
    input  logic                          fb_i,
    output logic signed [ERROR_WIDTH-1:0] error_o,
    output logic                          error_valid_o
`ifdef ADPLL_LOCK_DETECT_EN
    ,
    output logic                          lock_o
`endif
);

    localparam int unsigned CNT_W = ERROR_WIDTH - 1;
    localparam int unsigned SAT   = pdet_sat_limit(ERROR_WIDTH);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(SAT - 1);
    localparam logic [ERROR_WIDTH-1:0] SAT_MAG  = ERROR_WIDTH'(SAT);

    logic ref_edge;
    logic fb_edge;

    pdet_state_t                   state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          drain_ref_q, drain_ref_d;
    logic signed [ERROR_WIDTH-1:0] error_q, error_d;
    logic                          valid_q, valid_d;

    logic                   emit;
    logic                   emit_neg;
    logic [ERROR_WIDTH-1:0] emit_mag;
    logic [ERROR_WIDTH-1:0] k_mag;
    logic                   drain_opp;
    logic                   drain_same;

    edge_sync u_ref_sync (
        .clk_i   (gen_clk_i),
        .reset_i (reset_i),
        .d_i     (ref_i),
        .edge_o  (ref_edge)
    );

    edge_sync u_fb_sync (
        .clk_i   (gen_clk_i),
        .reset_i (reset_i),
        .d_i     (fb_i),
        .edge_o  (fb_edge)
    );

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            state_q     <= PDET_IDLE;
            cnt_q       <= '0;
            drain_ref_q <= 1'b0;
            error_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_ref_q <= drain_ref_d;
            error_q     <= error_d;
            valid_q     <= valid_d;
        end
    end

    // Measurement FSM; k_mag is the edge offset when the opposite edge lands this cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_ref_d = drain_ref_q;
        emit        = 1'b0;
        emit_neg    = 1'b0;
        emit_mag    = '0;
        k_mag       = ERROR_WIDTH'(cnt_q) + ERROR_WIDTH'(1);
        drain_opp   = drain_ref_q ? fb_edge : ref_edge;
        drain_same  = drain_ref_q ? ref_edge : fb_edge;

        case (state_q)
            PDET_IDLE: begin
                if (ref_edge && fb_edge) begin
                    emit = 1'b1;
                end else if (ref_edge) begin
                    state_d = PDET_REF_LEAD;
                    cnt_d   = '0;
                end else if (fb_edge) begin
                    state_d = PDET_FB_LEAD;
                    cnt_d   = '0;
                end
            end
            PDET_REF_LEAD, PDET_FB_LEAD: begin
                emit_neg = (state_q == PDET_FB_LEAD);
                if (emit_neg ? ref_edge : fb_edge) begin
                    emit     = 1'b1;
                    emit_mag = k_mag;
                    state_d  = PDET_IDLE;
                    cnt_d    = '0;
                end else if (emit_neg ? fb_edge : ref_edge) begin
                    emit     = 1'b1;
                    emit_mag = SAT_MAG;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    emit        = 1'b1;
                    emit_mag    = SAT_MAG;
                    state_d     = PDET_DRAIN;
                    drain_ref_d = ~emit_neg;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PDET_DRAIN: begin
                if (drain_opp) begin
                    state_d = PDET_IDLE;
                end else if (drain_same) begin
                    state_d = drain_ref_q ? PDET_REF_LEAD : PDET_FB_LEAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PDET_IDLE;
                cnt_d   = '0;
            end
        endcase

        valid_d = emit;
        error_d = emit ? $signed(emit_neg ? (ERROR_WIDTH'(0) - emit_mag) : emit_mag) : error_q;
    end

    assign error_o       = error_q;
    assign error_valid_o = valid_q;

`ifdef ADPLL_LOCK_DETECT_EN
    localparam int unsigned LCK_W = $clog2(LOCK_COUNT + 1);
    localparam logic [LCK_W-1:0]       LOCK_FULL = LCK_W'(LOCK_COUNT);
    localparam logic [ERROR_WIDTH-1:0] TOL_MAG   = ERROR_WIDTH'(LOCK_TOL);

    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_q, lock_d;

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    // Lock updates on the same edge as the valid pulse it judges.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (emit) begin
            if ((emit_mag <= TOL_MAG) && (emit_mag != SAT_MAG)) begin
                lock_cnt_d = (lock_cnt_q == LOCK_FULL) ? LOCK_FULL : lock_cnt_q + LCK_W'(1);
                lock_d     = (lock_cnt_d == LOCK_FULL);
            end else begin
                lock_cnt_d = '0;
                lock_d     = 1'b0;
            end
        end
    end

    assign lock_o = lock_q;
`endif

endmodule

// File: tb/tb_phase_detector_counter.sv
// Directed table-driven bench for phase_detector_counter; lock checks under ADPLL_LOCK_DETECT_EN.
module tb_phase_detector_counter;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              ref_i;
    logic              fb_i;
    logic signed [5:0] error_o;
    logic              error_valid_o;
`ifdef ADPLL_LOCK_DETECT_EN
    logic              lock_o;
`endif

    int checks = 0;
    int errors = 0;
    int got_q[$];
    int lck_q[$];

    always #5 clk = ~clk;

    phase_detector_counter dut (
        .gen_clk_i     (clk),
        .reset_i       (reset_i),
        .ref_i         (ref_i),
        .fb_i          (fb_i),
        .error_o       (error_o),
        .error_valid_o (error_valid_o)
`ifdef ADPLL_LOCK_DETECT_EN
        ,
        .lock_o        (lock_o)
`endif
    );

    function automatic int lock_now();
`ifdef ADPLL_LOCK_DETECT_EN
        return int'(lock_o);
`else
        return 0;
`endif
    endfunction

    // Collect every valid sample with the lock level seen alongside it.
    always @(negedge clk) begin
        if (!reset_i && error_valid_o) begin
            got_q.push_back(int'(error_o));
            lck_q.push_back(lock_now());
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic hi(input int t, input int c);
        return (t >= 0) && (c >= t) && (c < t + 3);
    endfunction

    // Each event time launches a 3-cycle high pulse on that input.
    task automatic run_pair(input int r0, input int r1, input int f0, input int f1);
        int last;
        last = r0;
        if (r1 > last) last = r1;
        if (f0 > last) last = f0;
        if (f1 > last) last = f1;
        got_q.delete();
        lck_q.delete();
        for (int c = 0; c < last + 15; c++) begin
            ref_i = hi(r0, c) | hi(r1, c);
            fb_i  = hi(f0, c) | hi(f1, c);
            cycles(1);
        end
        ref_i = 1'b0;
        fb_i  = 1'b0;
    endtask

    typedef struct {
        int    r0;
        int    r1;
        int    f0;
        int    f1;
        int    n;
        int    e0;
        int    e1;
        string name;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{0, -1, 5, -1, 1, 5, 0, "ref_lead_5"};
        vecs[1]  = '{3, -1, 0, -1, 1, -3, 0, "fb_lead_3"};
        vecs[2]  = '{0, -1, 0, -1, 1, 0, 0, "same_cycle"};
        vecs[3]  = '{0, -1, 40, -1, 1, 31, 0, "ref_sat_late_fb"};
        vecs[4]  = '{0, -1, 4, -1, 1, 4, 0, "after_drain_4"};
        vecs[5]  = '{0, 10, 12, -1, 2, 31, 2, "ref_slip"};
        vecs[6]  = '{50, -1, 0, -1, 1, -31, 0, "fb_sat"};
        vecs[7]  = '{0, -1, 31, -1, 1, 31, 0, "ref_lead_31"};
        vecs[8]  = '{0, 7, 7, -1, 1, 7, 0, "opp_wins"};
        vecs[9]  = '{0, 40, 43, -1, 2, 31, 3, "drain_restart"};
        vecs[10] = '{8, -1, 0, 6, 2, -31, -2, "fb_slip"};
        vecs[11] = '{0, -1, 1, -1, 1, 1, 0, "ref_lead_1"};

        reset_i = 1'b1;
        ref_i   = 1'b0;
        fb_i    = 1'b0;
        cycles(1);
        for (int i = 0; i < 3; i++) begin
            ref_i = i[0];
            fb_i  = ~i[0];
            @(negedge clk);
            check("rst_error", int'(error_o), 0);
            check("rst_valid", int'(error_valid_o), 0);
            check("rst_lock", lock_now(), 0);
            cycles(1);
        end
        ref_i   = 1'b0;
        fb_i    = 1'b0;
        reset_i = 1'b0;
        cycles(5);

        for (int v = 0; v < 12; v++) begin
            run_pair(vecs[v].r0, vecs[v].r1, vecs[v].f0, vecs[v].f1);
            check({vecs[v].name, "_count"}, got_q.size(), vecs[v].n);
            if (got_q.size() >= 1) check({vecs[v].name, "_e0"}, got_q[0], vecs[v].e0);
            if (got_q.size() >= 2) check({vecs[v].name, "_e1"}, got_q[1], vecs[v].e1);
            @(negedge clk);
            check({vecs[v].name, "_hold"}, int'(error_o), (vecs[v].n == 2) ? vecs[v].e1 : vecs[v].e0);
            check({vecs[v].name, "_idle"}, int'(error_valid_o), 0);
            cycles(1);
        end

        // Input already high at reset release must not register an edge.
        reset_i = 1'b1;
        ref_i   = 1'b1;
        cycles(3);
        got_q.delete();
        reset_i = 1'b0;
        cycles(10);
        ref_i = 1'b0;
        cycles(40);
        check("high_at_release", got_q.size(), 0);
        run_pair(0, -1, 2, -1);
        check("post_release_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("post_release_e0", got_q[0], 2);

        // Reset during REF_LEAD discards the measurement.
        got_q.delete();
        ref_i = 1'b1;
        cycles(3);
        ref_i = 1'b0;
        cycles(4);
        reset_i = 1'b1;
        cycles(2);
        reset_i = 1'b0;
        cycles(45);
        check("mid_reset_no_valid", got_q.size(), 0);
        check("mid_reset_error", int'(error_o), 0);
        run_pair(0, -1, 6, -1);
        check("post_mid_reset_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("post_mid_reset_e0", got_q[0], 6);

`ifdef ADPLL_LOCK_DETECT_EN
        reset_i = 1'b1;
        cycles(2);
        reset_i = 1'b0;
        cycles(3);
        for (int i = 0; i < 16; i++) begin
            run_pair(0, -1, 1, -1);
            check("lock_seq_count", got_q.size(), 1);
            if (got_q.size() >= 1) begin
                check("lock_seq_err", got_q[0], 1);
                check("lock_seq_lock", lck_q[0], (i == 15) ? 1 : 0);
            end
        end
        run_pair(0, -1, 5, -1);
        check("unlock_count", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            check("unlock_err", got_q[0], 5);
            check("unlock_lock", lck_q[0], 0);
        end
        run_pair(0, -1, 1, -1);
        if (got_q.size() >= 1) check("relock_cleared", lck_q[0], 0);
        else check("relock_count", got_q.size(), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
